ndev_serial_host: RTL and testbench

Console-side driver for the NDEV_LED 8-bit debug-GPIO serial link: opens a serial session, clocks bytes out MSB-first over bit 0 with bit 7 as strobe, frames each byte with the 0x8F marker, and samples the peer's return bit on bit 6. Used as a console stand-in to exercise the modchip's debug-GPIO decoder on the bench and in loopback. It sits between a byte-stream client (valid/ready) and the eight debug pins.

---
 rtl/ndev_serial_pkg.sv | 13 +
 rtl/ndev_phase_timer.sv | 16 +
 rtl/ndev_serial_host.sv | 118 +++++++++++
 tb/tb_ndev_serial_host.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ndev_serial_pkg.sv
// ndev_serial_pkg: state encoding and pin-level constants shared by the NDEV_LED serial host and decoder.
package ndev_serial_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_OPEN0, ST_OPEN1, ST_WAIT, ST_BIT_LO, ST_BIT_HI, ST_FRAME_END, ST_CLOSE
    } ndev_state_e;
    localparam logic [7:0] NDEV_IDLE       = 8'h00;
    localparam logic [7:0] NDEV_OPEN_PRE   = 8'h0F;
    localparam logic [7:0] NDEV_FRAME      = 8'h8F;
    localparam logic [7:0] NDEV_CLOSE      = 8'h25;
    localparam int         NDEV_STROBE_BIT = 7;
    localparam int         NDEV_RET_BIT    = 6;
    localparam logic [7:0] NDEV_ZERO_MASK  = 8'h3E;
endpackage

// File: rtl/ndev_phase_timer.sv
// ndev_phase_timer: loadable down-counter; done_o is high in the last cycle of a phase.
module ndev_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign done_o = cnt_q == 8'd0;
endmodule

// File: rtl/ndev_serial_host.sv
// ndev_serial_host: console-side NDEV_LED serial driver; shifts bytes out on bit 0 with bit 7 strobe,
// and shifts the peer's return bit in from bit 6.
module ndev_serial_host
    import ndev_serial_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       session_start,
    input  logic       session_end,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic [7:0] dbg_out,
    output logic       dbg_b6_oe,
    input  logic       dbg_b6_in
);
    localparam logic [7:0] LOAD_VAL = 8'(PHASE_CYCLES - 1);

    ndev_state_e state_q, state_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [2:0]  bit_q, bit_d;
    logic        pend_q, pend_d, rx_valid_q, rx_valid_d, done;

    ndev_phase_timer u_timer (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (state_d != state_q),
        .load_val_i(LOAD_VAL),
        .done_o    (done)
    );

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        bit_d      = bit_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE:   if (session_start) state_d = ST_OPEN0;
            ST_OPEN0:  if (done) state_d = ST_OPEN1;
            ST_OPEN1:  if (done) state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_valid) begin
                    state_d = ST_BIT_LO;
                    tx_sh_d = tx_data;
                    bit_d   = 3'd7;
                end else if (session_end || pend_q) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_BIT_LO: if (done) state_d = ST_BIT_HI;
            ST_BIT_HI: begin
                if (done) begin
                    rx_sh_d = {rx_sh_q[6:0], dbg_b6_in};
                    tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                    state_d = bit_q == 3'd0 ? ST_FRAME_END : ST_BIT_LO;
                    if (bit_q == 3'd0) begin
                        rx_data_d  = {rx_sh_q[6:0], dbg_b6_in};
                        rx_valid_d = 1'b1;
                    end
                end
            end
            ST_FRAME_END: if (done) state_d = pend_q ? ST_CLOSE : ST_WAIT;
            ST_CLOSE:     if (done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // A close request seen anywhere in a session waits for the current frame to finish.
        pend_d = state_d == ST_IDLE ? 1'b0 : pend_q | (session_end && state_q != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bit_q      <= '0;
            pend_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            bit_q      <= bit_d;
            pend_q     <= pend_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        dbg_out = NDEV_FRAME;
        case (state_q)
            ST_IDLE:  dbg_out = NDEV_IDLE;
            ST_OPEN0: dbg_out = NDEV_OPEN_PRE;
            ST_CLOSE: dbg_out = NDEV_CLOSE;
            ST_BIT_LO, ST_BIT_HI: begin
                dbg_out                  = '0;
                dbg_out[NDEV_STROBE_BIT] = state_q == ST_BIT_HI;
                dbg_out[0]               = tx_sh_q[7];
            end
            default: ;
        endcase
    end

    assign tx_ready  = state_q == ST_WAIT;
    assign busy      = state_q != ST_IDLE;
    assign dbg_b6_oe = state_q == ST_IDLE || state_q == ST_OPEN0;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
endmodule

// File: tb/tb_ndev_serial_host.sv
// tb_ndev_serial_host: scoreboard bench with a behavioural peer that returns bytes one frame late.
module tb_ndev_serial_host;
    localparam int P = 4;

    logic       CLK = 0, RST = 1, session_start = 0, session_end = 0, tx_valid = 0, dbg_b6_in = 0;
    logic [7:0] tx_data = 0;
    logic       tx_ready, rx_valid, busy, dbg_b6_oe;
    logic [7:0] rx_data, dbg_out;

    ndev_serial_host #(.PHASE_CYCLES(P)) dut (
        .CLK(CLK), .RST(RST), .session_start(session_start), .session_end(session_end),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
        .rx_data(rx_data), .busy(busy), .dbg_out(dbg_out), .dbg_b6_oe(dbg_b6_oe),
        .dbg_b6_in(dbg_b6_in)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] exp_rx[$], ptxq[$];
    logic [7:0] peer_next = 8'h3C, peer_loaded = 8'h00, pat;
    logic [7:0] pcur = 0, prx = 0, prev = 0;
    logic       loopback = 0, prxv = 0;
    int         pk = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 200) begin
            tick(1);
            n++;
        end
        check("ready_timeout", tx_ready, 1);
    endtask

    task automatic start_session();
        session_start = 1;
        tick(1);
        session_start = 0;
        wait_ready();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        wait_ready();
        tx_valid    = 1;
        tx_data     = b;
        session_end = e;
        exp_rx.push_back(peer_loaded);
        ptxq.push_back(b);
        peer_loaded = loopback ? b : peer_next;
        tick(1);
        tx_valid    = 0;
        session_end = 0;
    endtask

    // Peer model and output monitor: decodes strobes, returns its loaded byte MSB-first on bit 6.
    always @(negedge CLK) begin
        if (RST) begin
            pk = 0; pcur = 0; prx = 0; prev = 0; prxv = 0; dbg_b6_in = 0;
        end else begin
            if (rx_valid) begin
                check("rx_pulse", prxv, 0);
                if (exp_rx.size() == 0) check("rx_unexpected", rx_valid, 0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            prxv = rx_valid;
            if (dbg_out != prev) begin
                if (dbg_out[7] && !prev[7] && dbg_out != 8'h8F) begin
                    check("zero_bits", dbg_out & 8'h7E, 0);
                    prx = {prx[6:0], dbg_out[0]};
                    pk++;
                    dbg_b6_in = pcur[3'(8 - pk)];
                end else if (pk == 8 && dbg_out == 8'h8F) begin
                    if (ptxq.size() == 0) check("peer_unexpected", pk, 0);
                    else check("peer_rx", prx, ptxq.pop_front());
                    pcur = loopback ? prx : peer_next;
                    pk = 0;
                end
                prev = dbg_out;
            end
        end
    end

    initial begin
        int n;
        tick(2);
        check("rst_dbg_out", dbg_out, 8'h00);
        check("rst_oe", dbg_b6_oe, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        RST = 0;
        tick(1);
        session_start = 1;
        tick(1);
        session_start = 0;
        check("open_busy", busy, 1);
        for (int i = 0; i < P; i++) begin
            check("open0", dbg_out, 8'h0F);
            check("open0_oe", dbg_b6_oe, 1);
            tick(1);
        end
        for (int i = 0; i < P; i++) begin
            check("open1", dbg_out, 8'h8F);
            check("open1_oe", dbg_b6_oe, 0);
            check("open1_ready", tx_ready, 0);
            tick(1);
        end
        check("wait_ready", tx_ready, 1);
        check("wait_dbg", dbg_out, 8'h8F);

        pat = 8'hA5;
        send_byte(pat, 0);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < P; j++) begin
                check("bit_lo", dbg_out, {7'b0, pat[7 - k]});
                check("frame_ready", tx_ready, 0);
                tick(1);
            end
            for (int j = 0; j < P; j++) begin
                check("bit_hi", dbg_out, {1'b1, 6'b0, pat[7 - k]});
                tick(1);
            end
        end
        check("frame_end", dbg_out, 8'h8F);

        send_byte(8'h5A, 1);
        tick(16 * P);
        for (int i = 0; i < P; i++) begin
            check("close_frame_end", dbg_out, 8'h8F);
            tick(1);
        end
        for (int i = 0; i < P; i++) begin
            check("close", dbg_out, 8'h25);
            tick(1);
        end
        check("closed_dbg", dbg_out, 8'h00);
        check("closed_busy", busy, 0);
        check("closed_oe", dbg_b6_oe, 1);

        start_session();
        send_byte(8'h11, 0);
        tick(9 * P + 1);
        check("hi5_strobe", dbg_out[7], 1);
        RST = 1;
        void'(exp_rx.pop_back());
        void'(ptxq.pop_back());
        peer_loaded = 8'h00;
        tick(1);
        check("midrst_dbg", dbg_out, 8'h00);
        check("midrst_oe", dbg_b6_oe, 1);
        check("midrst_busy", busy, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        RST = 0;
        tick(1);

        loopback = 1;
        start_session();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h55, 0);
        send_byte(8'hA3, 1);
        n = 0;
        while (busy && n < 2000) begin
            tick(1);
            n++;
        end
        check("idle_timeout", busy, 0);
        tick(2);
        check("sb_rx_empty", exp_rx.size(), 0);
        check("sb_peer_empty", ptxq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
